imm_gen_pipelined: RTL and testbench

Registered, parametrised immediate generator for the decode stage. Accepts one 32-bit instruction plus PC per handshake. Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) to XLEN bits and computes the PC-relative target. Results go through a DEPTH-entry output queue with valid/ready flow control, so fetch and decode can stall independently. Keeps a saturating count of illegal opcodes for debug.

---
 rtl/imm_gen_pipelined.sv | 208 ++++++++++++++++++++
 tb/tb_imm_gen_pipelined.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipelined.sv
// Registered RV32I/RV64I immediate and PC-relative target decoder with an output queue.
// Latency: 1 cycle from accept to the queue head; the queue has no input-to-output combinational path.
// Backpressure: inReady drops while DEPTH entries are held; a pop while full does not free a slot that cycle.

module imm_gen_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    // An empty queue presents all-zero data rather than a stale slot.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module imm_gen_pipelined #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  inPc,
    output logic             outValid,
    input  logic             outReady,
    output logic [XLEN-1:0]  outImmediate,
    output logic [XLEN-1:0]  outTarget,
    output logic [2:0]       outFormat,
    output logic             outIllegal,
    output logic [CNT_W-1:0] illegalCount
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] shamt_full;
    logic [XLEN-1:0] shamt_w;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic            use_target;
    entry_t          dec_entry;
    entry_t          head_entry;
    logic            q_empty;
    logic            q_full;
    logic            push;
    logic            pop;

    assign opcode     = instruction[6:0];
    assign funct3     = instruction[14:12];
    assign is_shift   = (funct3[1:0] == 2'b01);
    assign imm_i      = XLEN'($signed(instruction[31:20]));
    assign shamt_full = (XLEN == 64) ? XLEN'(instruction[25:20]) : XLEN'(instruction[24:20]);
    assign shamt_w    = XLEN'(instruction[24:20]);

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        use_target  = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                dec_imm = is_shift ? shamt_full : imm_i;
            end
            7'b0011011: begin
                // Word-sized OP-IMM only exists on RV64.
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = is_shift ? shamt_w : imm_i;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
            end
            7'b1100011: begin
                dec_fmt    = FMT_B;
                dec_imm    = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                            instruction[11:8], 1'b0}));
                use_target = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt    = FMT_U;
                dec_imm    = XLEN'($signed({instruction[31:12], 12'b0}));
                use_target = opcode[4] && !opcode[5];
            end
            7'b1101111: begin
                dec_fmt    = FMT_J;
                dec_imm    = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                            instruction[30:21], 1'b0}));
                use_target = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.imm     = dec_imm;
        dec_entry.target  = use_target ? (inPc + dec_imm) : '0;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
    end

    assign inReady = !q_full;
    assign push    = inValid && inReady;
    assign pop     = outValid && outReady;

    imm_gen_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (dec_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .empty    (q_empty),
        .full     (q_full)
    );

    assign outValid     = !q_empty;
    assign outImmediate = head_entry.imm;
    assign outTarget    = head_entry.target;
    assign outFormat    = head_entry.fmt;
    assign outIllegal   = head_entry.illegal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegalCount <= '0;
        end else if (push && dec_illegal && (illegalCount != '1)) begin
            illegalCount <= illegalCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_gen_pipelined.sv
// Directed bench: three instances cover the default RV32 build, a 2-bit illegal counter and RV64.
module tb_imm_gen_pipelined;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // RV32, DEPTH=2, CNT_W=16
    logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_instr, a_pc, a_out_imm, a_out_target;
    logic [2:0]  a_out_fmt;
    logic [15:0] a_cnt;

    // RV32, CNT_W=2
    logic        c_reset, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_illegal;
    logic [31:0] c_instr, c_pc, c_out_imm, c_out_target;
    logic [2:0]  c_out_fmt;
    logic [1:0]  c_cnt;

    // RV64
    logic        d_reset, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_illegal;
    logic [31:0] d_instr;
    logic [63:0] d_pc, d_out_imm, d_out_target;
    logic [2:0]  d_out_fmt;
    logic [15:0] d_cnt;

    imm_gen_pipelined #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut_a (
        .clock(clock), .reset(a_reset), .inValid(a_in_valid), .inReady(a_in_ready),
        .instruction(a_instr), .inPc(a_pc), .outValid(a_out_valid), .outReady(a_out_ready),
        .outImmediate(a_out_imm), .outTarget(a_out_target), .outFormat(a_out_fmt),
        .outIllegal(a_out_illegal), .illegalCount(a_cnt)
    );

    imm_gen_pipelined #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_c (
        .clock(clock), .reset(c_reset), .inValid(c_in_valid), .inReady(c_in_ready),
        .instruction(c_instr), .inPc(c_pc), .outValid(c_out_valid), .outReady(c_out_ready),
        .outImmediate(c_out_imm), .outTarget(c_out_target), .outFormat(c_out_fmt),
        .outIllegal(c_out_illegal), .illegalCount(c_cnt)
    );

    imm_gen_pipelined #(.XLEN(64), .DEPTH(2), .CNT_W(16)) dut_d (
        .clock(clock), .reset(d_reset), .inValid(d_in_valid), .inReady(d_in_ready),
        .instruction(d_instr), .inPc(d_pc), .outValid(d_out_valid), .outReady(d_out_ready),
        .outImmediate(d_out_imm), .outTarget(d_out_target), .outFormat(d_out_fmt),
        .outIllegal(d_out_illegal), .illegalCount(d_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_send(input logic [31:0] instr, input logic [31:0] pc);
        a_in_valid = 1'b1;
        a_instr    = instr;
        a_pc       = pc;
        step();
        a_in_valid = 1'b0;
        a_instr    = 32'hDEAD_BEEF;
        a_pc       = 32'h5555_5555;
    endtask

    task automatic a_expect(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                            input logic [2:0] fmt, input logic ill);
        chk({tag, ".valid"}, 64'(a_out_valid), 64'd1);
        chk({tag, ".imm"}, 64'(a_out_imm), 64'(imm));
        chk({tag, ".target"}, 64'(a_out_target), 64'(tgt));
        chk({tag, ".fmt"}, 64'(a_out_fmt), 64'(fmt));
        chk({tag, ".illegal"}, 64'(a_out_illegal), 64'(ill));
    endtask

    task automatic d_send(input logic [31:0] instr, input logic [63:0] pc);
        d_in_valid = 1'b1;
        d_instr    = instr;
        d_pc       = pc;
        step();
        d_in_valid = 1'b0;
    endtask

    logic [1:0] sat_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        a_reset = 1'b0; c_reset = 1'b0; d_reset = 1'b0;
        a_in_valid = 1'b0; c_in_valid = 1'b0; d_in_valid = 1'b0;
        a_out_ready = 1'b1; c_out_ready = 1'b1; d_out_ready = 1'b1;
        a_instr = '0; c_instr = '0; d_instr = '0;
        a_pc = '0; c_pc = '0; d_pc = '0;

        // Reset state, sampled while the edge still toggles under reset.
        #12;
        chk("rst.valid", 64'(a_out_valid), 64'd0);
        chk("rst.imm", 64'(a_out_imm), 64'd0);
        chk("rst.target", 64'(a_out_target), 64'd0);
        chk("rst.fmt", 64'(a_out_fmt), 64'd0);
        chk("rst.illegal", 64'(a_out_illegal), 64'd0);
        chk("rst.count", 64'(a_cnt), 64'd0);
        chk("rst.c_count", 64'(c_cnt), 64'd0);
        a_reset = 1'b1; c_reset = 1'b1; d_reset = 1'b1;
        step();
        chk("rst.in_ready", 64'(a_in_ready), 64'd1);
        chk("rst.valid_after", 64'(a_out_valid), 64'd0);

        // Format decode on RV32, one entry per cycle with the consumer always ready.
        a_send(32'hFFC12083, 32'h0);       a_expect("lw", 32'hFFFFFFFC, 32'h0, 3'd1, 1'b0);
        a_send(32'h00512423, 32'h0);       a_expect("sw", 32'h8, 32'h0, 3'd2, 1'b0);
        a_send(32'h123450B7, 32'h40);      a_expect("lui", 32'h12345000, 32'h0, 3'd4, 1'b0);
        a_send(32'hFE000CE3, 32'h100);     a_expect("beq", 32'hFFFFFFF8, 32'hF8, 3'd3, 1'b0);
        a_send(32'hFE000CE3, 32'h4);       a_expect("beq_wrap", 32'hFFFFFFF8, 32'hFFFFFFFC, 3'd3, 1'b0);
        a_send(32'h00001097, 32'h200);     a_expect("auipc", 32'h1000, 32'h1200, 3'd4, 1'b0);
        a_send(32'h008000EF, 32'h10);      a_expect("jal", 32'h8, 32'h18, 3'd5, 1'b0);
        a_send(32'hFFF00093, 32'h10);      a_expect("addi_m1", 32'hFFFFFFFF, 32'h0, 3'd1, 1'b0);
        a_send(32'h40315093, 32'h0);       a_expect("srai", 32'h3, 32'h0, 3'd1, 1'b0);
        a_send(32'h0000001B, 32'h0);       a_expect("opimm32_rv32", 32'h0, 32'h0, 3'd0, 1'b1);
        chk("a_count_one", 64'(a_cnt), 64'd1);
        step();
        chk("drain.valid", 64'(a_out_valid), 64'd0);
        chk("drain.imm", 64'(a_out_imm), 64'd0);

        // Backpressure: consumer stalled, three back-to-back offers.
        a_out_ready = 1'b0;
        a_send(32'h00100093, 32'h0);
        chk("bp.ready_after1", 64'(a_in_ready), 64'd1);
        a_send(32'h00200093, 32'h0);
        chk("bp.ready_full", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b1;
        a_instr    = 32'h00300093;
        step();
        chk("bp.held_ready", 64'(a_in_ready), 64'd0);
        chk("bp.head_first", 64'(a_out_imm), 64'd1);
        a_out_ready = 1'b1;
        step();
        chk("bp.head_second", 64'(a_out_imm), 64'd2);
        chk("bp.ready_free", 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        chk("bp.head_third", 64'(a_out_imm), 64'd3);
        chk("bp.third_valid", 64'(a_out_valid), 64'd1);
        step();
        chk("bp.empty", 64'(a_out_valid), 64'd0);

        // Saturating illegal counter with a 2-bit width.
        c_in_valid = 1'b1;
        c_instr    = 32'h0000007F;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ill%0d.illegal", i), 64'(c_out_illegal), 64'd1);
            chk($sformatf("ill%0d.imm", i), 64'(c_out_imm), 64'd0);
            chk($sformatf("ill%0d.count", i), 64'(c_cnt), 64'(sat_seq[i]));
        end
        c_instr = 32'h00100093;
        step();
        c_in_valid = 1'b0;
        chk("ill.legal_no_inc", 64'(c_cnt), 64'd3);
        chk("ill.legal_flag", 64'(c_out_illegal), 64'd0);

        // RV64 decode.
        d_send(32'h02809093, 64'h0);
        chk("rv64.slli40", d_out_imm, 64'h28);
        d_send(32'hFE000CE3, 64'h100);
        chk("rv64.beq_imm", d_out_imm, 64'hFFFFFFFFFFFFFFF8);
        chk("rv64.beq_target", d_out_target, 64'hF8);
        d_send(32'h80000037, 64'h0);
        chk("rv64.lui_sext", d_out_imm, 64'hFFFFFFFF80000000);
        d_send(32'h0050909B, 64'h0);
        chk("rv64.slliw", d_out_imm, 64'h5);
        chk("rv64.slliw_legal", 64'(d_out_illegal), 64'd0);

        // Asynchronous reset with two queued entries.
        d_out_ready = 1'b0;
        d_send(32'h00100093, 64'h0);
        d_send(32'h00200093, 64'h0);
        chk("mid.full", 64'(d_in_ready), 64'd0);
        #2;
        d_reset = 1'b0;
        #1;
        chk("mid.valid", 64'(d_out_valid), 64'd0);
        chk("mid.imm", d_out_imm, 64'd0);
        chk("mid.ready", 64'(d_in_ready), 64'd1);
        @(negedge clock);
        d_reset = 1'b1;
        step();
        step();
        chk("mid.no_stale", 64'(d_out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
